// File: rtl/code_nibble_packer_pkg.sv
// Shared types and constants for the CODE nibble packer.
package codec_pkg;

  localparam int CODE_W       = 4;
  localparam int WORD_W       = 16;
  localparam int NIB_PER_WORD = 4;

  // One packed word as it travels through the FIFO.
  typedef struct packed {
    logic [WORD_W-1:0] data;  // MSB-first nibbles
    logic [2:0]        nib;   // valid nibbles, 1..4
    logic              last;  // produced by a flush
  } packed_word_t;

  // COLLECT: normal accumulation.
  // HOLD: one-cycle marker after a word was dropped because the FIFO was full.
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/code_nibble_packer_if.sv
// Bundle of the CODE input stream and the packed-word output stream.
//
// Handshake: the CODE side has no backpressure; a nibble is taken at every
// posedge where code_vld = 1. On the word side a transfer happens at a posedge
// where word_vld && word_rdy; word_vld never depends on word_rdy, and the head
// word stays stable until it is transferred.
interface code_nibble_packer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]       code_in;
  logic             code_vld;
  logic             flush;
  logic [15:0]      word_out;
  logic [2:0]       word_nib;
  logic             word_last;
  logic             word_vld;
  logic             word_rdy;
  logic [CNT_W-1:0] fill_cnt;
  logic             overflow;

  // Producer/consumer side (environment driving the packer).
  modport master (
    output code_in, code_vld, flush, word_rdy,
    input  word_out, word_nib, word_last, word_vld, fill_cnt, overflow
  );

  // Packer side.
  modport slave (
    input  code_in, code_vld, flush, word_rdy,
    output word_out, word_nib, word_last, word_vld, fill_cnt, overflow
  );

endinterface

// File: rtl/code_nibble_packer_fifo.sv
// Synchronous FIFO of packed words. Push and pop on the same edge are both
// honoured; a pop while empty is ignored; a push while full is accepted only
// if a pop frees the slot on that same edge. No bypass: a word pushed into an
// empty FIFO shows on the head the following cycle.
module packer_fifo
  import codec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  packed_word_t                 data_i,
  input  logic                         pop_i,
  output packed_word_t                 head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  packed_word_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Head reads as zero while empty so stale entries never show.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Accept/advance decisions; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/code_nibble_packer.sv
// Packs the 4-bit CODE stream MSB-first into 16-bit words, supports a flush
// that pads and tags a partial word, and buffers words in a small FIFO.
module code_nibble_packer
  import codec_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
  input  logic                        CLK,
  input  logic                        RESET_,
  code_nibble_packer_if.slave         bus,
  output state_t                      dbg_state_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [1:0]        nib_cnt_q, nib_cnt_d;
  logic              overflow_q, overflow_d;
  state_t            state_q, state_d;

  logic [WORD_W-1:0] acc_with;
  logic [2:0]        k_after;
  logic              complete;
  logic              flush_push;
  logic              push_req;
  logic              drop;
  packed_word_t      push_word;
  packed_word_t      head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // Fold in this cycle's nibble and build the word that would be pushed.
  always_comb begin
    acc_with = acc_q;
    for (int i = 0; i < NIB_PER_WORD; i++) begin
      if (bus.code_vld && (i == int'(nib_cnt_q)))
        acc_with[WORD_W-1-CODE_W*i -: CODE_W] = bus.code_in;
    end
    k_after    = {1'b0, nib_cnt_q} + {2'b00, bus.code_vld};
    complete   = bus.code_vld && (nib_cnt_q == 2'd3);
    // A flush only matters for a non-empty partial word; a word completed on
    // the same edge already closes itself.
    flush_push = bus.flush && !complete && (k_after != 3'd0);
    push_req   = complete || flush_push;
    push_word  = '0;
    for (int i = 0; i < NIB_PER_WORD; i++) begin
      if (i < int'(k_after))
        push_word.data[WORD_W-1-CODE_W*i -: CODE_W] = acc_with[WORD_W-1-CODE_W*i -: CODE_W];
      else
        push_word.data[WORD_W-1-CODE_W*i -: CODE_W] = PAD_NIBBLE;
    end
    push_word.nib  = k_after;
    push_word.last = flush_push;
    // Full FIFO only frees a slot if the consumer pops on this edge.
    drop = push_req && fifo_full && !bus.word_rdy;
  end

  // Next-state logic: FSM, counter, accumulator and sticky overflow.
  always_comb begin
    state_d    = state_q;
    nib_cnt_d  = nib_cnt_q;
    acc_d      = acc_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_COLLECT: if (drop) state_d = ST_HOLD;
      ST_HOLD:    state_d = drop ? ST_HOLD : ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
    if (push_req)          nib_cnt_d = 2'd0;
    else if (bus.code_vld) nib_cnt_d = nib_cnt_q + 2'd1;
    // Slots beyond the valid count are masked when a word is built, so the
    // accumulator never needs clearing between words.
    acc_d = acc_with;
    if (drop) overflow_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      state_q    <= ST_COLLECT;
      nib_cnt_q  <= 2'd0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_cnt_q  <= nib_cnt_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

  packer_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_),
    .push_i  (push_req),
    .data_i  (push_word),
    .pop_i   (bus.word_rdy),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.word_out  = head.data;
  assign bus.word_nib  = head.nib;
  assign bus.word_last = head.last;
  assign bus.word_vld  = !fifo_empty;
  assign bus.fill_cnt  = fifo_count;
  assign bus.overflow  = overflow_q;
  assign dbg_state_o   = state_q;

endmodule
